sync_fifo_wr_arb: RTL
=====================

// Module: sync_fifo_wr_arb
// PURPOSE
//  Round-robin write arbiter sharing one sync FIFO write port among N_REQ producers.
//  Per-requester valid/ready in; drives FIFO wen/data plus source ID for a side channel.
//  Optional burst lock keeps a grant up to MAX_BURST beats so a source's words stay contiguous.
//  The FIFO has no overflow guard, so this block never writes while fifo_full is high.
// PARAMETERS
//  N_REQ      4      number of requesters (>=2)
//  MAX_BURST  4      max consecutive beats per grant (>=1; 1 = pure per-beat round robin)
//  T          logic  payload type (parameter type), same T as the downstream FIFO
//  IDW        derived: $clog2(N_REQ), source-ID width
// PORTS
//  clk         in   1        clock
//  rst_n       in   1        asynchronous active-low reset
//  req_valid   in   N_REQ    requester i has a word on req_data[i]
//  req_data    in   T[N_REQ] requester payloads
//  req_ready   out  N_REQ    word on requester i accepted this cycle (one-hot or 0)
//  fifo_full   in   1        downstream FIFO full
//  fifo_wen    out  1        FIFO write enable
//  fifo_wdata  out  T        FIFO write data = req_data[owner]
//  fifo_wsrc   out  IDW      index of source being written (valid when fifo_wen=1)
//  burst_busy  out  1        state == BURST
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
//  Reset: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, arb_en=0 -> all outputs 0.
//  arb_en: 1-bit flop, set on the first clk edge with rst_n high.
//   fifo_wen, req_ready and burst_busy are forced to 0 while arb_en=0.
//  Transfer: beat moves when fifo_wen=1, in the same cycle (zero latency).
//   fifo_wen=1 implies exactly one req_ready bit is set.
//   req_ready[i] = fifo_wen & (sel==i).
//   fifo_wen is never 1 while fifo_full=1; fifo_wdata/fifo_wsrc are don't-care when fifo_wen=0.
//  IDLE state:
//   sel = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
//   fifo_wen = arb_en & |req_valid & !fifo_full.
//   On a transfer: rr_ptr <= (sel+1) mod N_REQ and owner <= sel.
//     If MAX_BURST>1: beat_cnt <= 1, go to BURST.
//     If MAX_BURST=1: stay in IDLE.
//  BURST state:
//   Only the owner is served.
//   fifo_wen = req_valid[owner] & !fifo_full; each transfer does beat_cnt++.
//   Return to IDLE (beat_cnt <= 0) on either:
//     (a) the transfer that makes beat_cnt==MAX_BURST, or
//     (b) a cycle with req_valid[owner]=0. No transfer occurs in that cycle (one dead cycle).
//   fifo_full=1 with owner valid: stall. No transfer, state/beat_cnt/owner held, lock kept.
//  beat_cnt width: $clog2(MAX_BURST+1); it never exceeds MAX_BURST.
//  rr_ptr wraps from N_REQ-1 to 0.
//  The first grant after a burst in IDLE follows rr_ptr, so the previous owner is last in priority.
//  Async reset mid-burst: outputs drop to 0 immediately and all state returns to reset values.
//   Any beat in flight is not written.
// TESTING
//  T1 reset: all req_valid=1 during and after rst_n release -> fifo_wen=0 on the first edge.
//     First write on the next cycle, fifo_wsrc=0.
//  T2 MAX_BURST=1, N_REQ=4, all valid, fifo_full=0 -> fifo_wsrc 0,1,2,3,0,1...
//     One write every cycle.
//  T3 MAX_BURST=4, req0 and req2 always valid -> fifo_wsrc 0x4, then 2x4, then 0x4...
//     No gap cycles; burst_busy high from the 2nd beat through the 4th beat of each burst.
//  T4 mid-burst stall: fifo_full=1 for 3 cycles after beat 2 of owner 1.
//     Result: fifo_wen=0 and req_ready=0 for 3 cycles, then beats 3 and 4 from source 1, then rotate.
//  T5 owner drop: owner 0 drops valid after 2 beats while req1 and req3 are valid.
//     Result: one cycle with fifo_wen=0, then source 1 is granted.
//  T6 reset mid-burst: assert rst_n low at beat 2 -> outputs 0 in the same cycle.
//     After release, arbitration restarts at rr_ptr=0.

Source files
------------

// File: rtl/sync_fifo_wr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_fifo_wr_arb
// Description : Round-robin write arbiter that shares one synchronous FIFO
//               write port among N_REQ producers. An optional burst lock
//               holds a grant for up to MAX_BURST consecutive beats so one
//               source's words land contiguously in the FIFO. The block
//               never writes while fifo_full is high.
// Ports       : clk, rst_n            clock / async active-low reset
//               req_valid[N_REQ]      per-requester word available
//               req_data[N_REQ]       per-requester payload (type T)
//               req_ready[N_REQ]      one-hot accept, set only when fifo_wen
//               fifo_full             downstream FIFO full
//               fifo_wen              FIFO write enable
//               fifo_wdata            payload of the granted source
//               fifo_wsrc             index of the granted source
//               burst_busy            arbiter is locked to a burst owner
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_wr_arb #(
  parameter int  N_REQ     = 4,
  parameter int  MAX_BURST = 4,
  parameter type T         = logic,
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_valid,
  input  T                 req_data [N_REQ],
  output logic [N_REQ-1:0] req_ready,
  input  logic             fifo_full,
  output logic             fifo_wen,
  output T                 fifo_wdata,
  output logic [IDW-1:0]   fifo_wsrc,
  output logic             burst_busy
);

  localparam int             c_bcw        = $clog2(MAX_BURST + 1);
  localparam logic [c_bcw-1:0] c_max_beats = c_bcw'(MAX_BURST);
  localparam logic [IDW:0]   c_n_wide     = (IDW + 1)'(N_REQ);
  localparam logic [IDW-1:0] c_last_idx   = IDW'(N_REQ - 1);

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_burst = 1'b1;

  logic [0:0]       r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_owner;
  logic [c_bcw-1:0] r_beat_cnt;
  logic             r_arb_en;

  logic [IDW-1:0]   w_scan_sel;
  logic             w_scan_hit;
  logic [IDW-1:0]   w_sel;
  logic [IDW-1:0]   w_sel_inc;
  logic             w_want;
  logic             w_burst_last;

  // Rotating priority scan: first valid requester starting at r_rr_ptr.
  // The index sum stays below 2*N_REQ, so one conditional subtract wraps it.
  always_comb begin
    logic [IDW:0] idx;
    w_scan_sel = r_rr_ptr;
    w_scan_hit = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, r_rr_ptr} + (IDW + 1)'(k);
      if (idx >= c_n_wide) begin
        idx = idx - c_n_wide;
      end
      if (!w_scan_hit && req_valid[idx[IDW-1:0]]) begin
        w_scan_sel = idx[IDW-1:0];
        w_scan_hit = 1'b1;
      end
    end
  end

  // While locked only the owner is eligible; otherwise the scan result wins.
  assign w_sel        = (r_state == c_st_burst) ? r_owner : w_scan_sel;
  assign w_want       = (r_state == c_st_burst) ? req_valid[r_owner] : w_scan_hit;
  assign w_sel_inc    = (w_sel == c_last_idx) ? '0 : w_sel + IDW'(1);
  assign w_burst_last = (r_beat_cnt + c_bcw'(1)) == c_max_beats;

  assign fifo_wen   = r_arb_en & w_want & ~fifo_full;
  assign fifo_wdata = req_data[w_sel];
  assign fifo_wsrc  = w_sel;
  assign burst_busy = r_arb_en & (r_state == c_st_burst);

  for (genvar i = 0; i < N_REQ; i++) begin : g_ready
    assign req_ready[i] = fifo_wen & (w_sel == IDW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_arb_en   <= 1'b0;
    end else begin
      // Holds all outputs low for the first cycle out of reset.
      r_arb_en <= 1'b1;
      case (r_state)
        c_st_idle: begin
          if (fifo_wen) begin
            // Granted source moves to the back of the rotation.
            r_rr_ptr <= w_sel_inc;
            r_owner  <= w_sel;
            if (MAX_BURST > 1) begin
              r_beat_cnt <= c_bcw'(1);
              r_state    <= c_st_burst;
            end
          end
        end
        c_st_burst: begin
          if (fifo_wen) begin
            if (w_burst_last) begin
              r_beat_cnt <= '0;
              r_state    <= c_st_idle;
            end else begin
              r_beat_cnt <= r_beat_cnt + c_bcw'(1);
            end
          end else if (!req_valid[r_owner]) begin
            // Owner went idle: release the lock, no beat this cycle.
            r_beat_cnt <= '0;
            r_state    <= c_st_idle;
          end
          // fifo_full with owner valid: stall, lock and count held.
        end
        default: begin
          r_beat_cnt <= '0;
          r_state    <= c_st_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
